// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard request and pipeline control bundle.
// master drives the D instruction fields, slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int TW     = 3
);
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_tuse_rs;
  logic [TW-1:0]     d_tuse_rt;
  logic [REG_AW-1:0] d_a3;
  logic [TW-1:0]     d_tprod;
  logic              d_mdu_use;
  logic [1:0]        d_mdu_op;
  logic              ext_stall;
  logic              flush;
  logic              stall_fd;
  logic              clr_de;
  logic [1:0]        fwd_rs_d;
  logic [1:0]        fwd_rt_d;
  logic [1:0]        fwd_rs_e;
  logic [1:0]        fwd_rt_e;
  logic [1:0]        fwd_rt_m;
  logic              mdu_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    output d_a3, d_tprod, d_mdu_use, d_mdu_op,
    output ext_stall, flush,
    input  stall_fd, clr_de,
    input  fwd_rs_d, fwd_rt_d, fwd_rs_e,
    input  fwd_rt_e, fwd_rt_m, mdu_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    input  d_a3, d_tprod, d_mdu_use, d_mdu_op,
    input  ext_stall, flush,
    output stall_fd, clr_de,
    output fwd_rs_d, fwd_rt_d, fwd_rs_e,
    output fwd_rt_e, fwd_rt_m, mdu_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadow-state hazard/forwarding controller for the F/D/E/M/W pipe.
// Define HAZARD_MDU_EN to build the MDU busy counter and MDU stall.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int TW       = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [TW-1:0]     tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } ent_t;

  typedef struct packed {
    logic          hit;
    logic [TW-1:0] tnew;
    logic [1:0]    sel;
  } hit_t;

  ent_t r_e, r_m, r_w;
  ent_t w_d;
  hit_t w_h_rs_d, w_h_rt_d;
  hit_t w_h_rs_e, w_h_rt_e, w_h_rt_m;
  logic w_opnd_stall;
  logic w_mdu_stall;
  logic w_hz;
  logic w_unused_sh;

  function automatic logic match(
    input ent_t x,
    input logic [REG_AW-1:0] s
  );
    return (x.a3 != '0) && (x.a3 == s);
  endfunction

  // youngest matching stage wins: E, then M, then W
  function automatic hit_t find(
    input logic [REG_AW-1:0] s,
    input ent_t e,
    input ent_t m,
    input ent_t w
  );
    hit_t h;
    h = '0;
    if (match(e, s)) begin
      h.hit  = 1'b1;
      h.tnew = e.tnew;
      h.sel  = 2'd1;
    end else if (match(m, s)) begin
      h.hit  = 1'b1;
      h.tnew = m.tnew;
      h.sel  = 2'd2;
    end else if (match(w, s)) begin
      h.hit  = 1'b1;
      h.tnew = w.tnew;
      h.sel  = 2'd3;
    end
    return h;
  endfunction

  function automatic logic [1:0] fsel(input hit_t h);
    return (h.hit && h.tnew == '0) ? h.sel : 2'd0;
  endfunction

  function automatic logic need(
    input hit_t h,
    input logic [TW-1:0] tuse
  );
    return h.hit && (tuse != '1) && (h.tnew > tuse);
  endfunction

  function automatic ent_t age(input ent_t x);
    ent_t y;
    y = x;
    if (x.tnew != '0) y.tnew = x.tnew - TW'(1);
    return y;
  endfunction

  assign w_d = '{
    a3:   bus.d_a3,
    tnew: bus.d_tprod,
    rs:   bus.d_rs,
    rt:   bus.d_rt
  };

  // dependency lookup for D operands and for in-flight E/M operands
  always_comb begin
    w_h_rs_d = find(bus.d_rs, r_e, r_m, r_w);
    w_h_rt_d = find(bus.d_rt, r_e, r_m, r_w);
    w_h_rs_e = find(r_e.rs, '0, r_m, r_w);
    w_h_rt_e = find(r_e.rt, '0, r_m, r_w);
    w_h_rt_m = find(r_m.rt, '0, '0, r_w);
  end

  assign w_opnd_stall =
    need(w_h_rs_d, bus.d_tuse_rs) |
    need(w_h_rt_d, bus.d_tuse_rt);

  assign w_hz = w_opnd_stall | w_mdu_stall;

  assign bus.stall_fd = rst_n & (w_hz | bus.ext_stall);
  assign bus.clr_de   = rst_n & w_hz
                      & ~bus.ext_stall & ~bus.flush;

  assign bus.fwd_rs_d = fsel(w_h_rs_d);
  assign bus.fwd_rt_d = fsel(w_h_rt_d);
  assign bus.fwd_rs_e = fsel(w_h_rs_e);
  assign bus.fwd_rt_e = fsel(w_h_rt_e);
  assign bus.fwd_rt_m = fsel(w_h_rt_m);

  assign w_unused_sh = ^{r_w.rs, r_w.rt};

  // shadow pipeline: flush beats freeze, freeze beats advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else if (bus.flush) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= age(r_m);
    end else if (!bus.ext_stall) begin
      r_w <= age(r_m);
      r_m <= age(r_e);
      r_e <= w_hz ? '0 : w_d;
    end
  end

`ifdef HAZARD_MDU_EN
  logic [1:0]       r_e_op;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_d_op;
  logic             w_adv;

  assign w_adv  = ~bus.ext_stall & ~bus.flush;
  assign w_d_op = (bus.d_mdu_op == 2'b11) ?
                  2'b00 : bus.d_mdu_op;

  assign w_mdu_stall = bus.d_mdu_use
                     & ((r_cnt != '0) | (r_e_op != 2'b00));
  assign bus.mdu_busy = (r_cnt != '0);

  // MDU opcode rides alongside the E shadow entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_op <= 2'b00;
    end else if (bus.flush) begin
      r_e_op <= 2'b00;
    end else if (!bus.ext_stall) begin
      r_e_op <= w_hz ? 2'b00 : w_d_op;
    end
  end

  // busy counter loads as mult/div leaves E, else runs down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_adv && r_e_op == 2'b01) begin
      r_cnt <= CNT_W'(MULT_CYC);
    end else if (w_adv && r_e_op == 2'b10) begin
      r_cnt <= CNT_W'(DIV_CYC);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
`else
  logic w_unused_mdu;

  assign w_unused_mdu = ^{bus.d_mdu_use, bus.d_mdu_op};
  assign w_mdu_stall  = 1'b0;
  assign bus.mdu_busy = 1'b0;
`endif

endmodule
